// File: rtl/reg_dump_sequencer.sv
// rtl/reg_dump_sequencer.sv - walks a register mask through the core debug port and streams values out
// Each frame dumps every masked register, then pulses switch_run to advance the core.
module reg_dump_sequencer #(
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 5,
  parameter int SETTLE_CYCLES = 4,
  parameter int GAP_CYCLES    = 2,
  parameter int RUN_CYCLES    = 16,
  parameter int PERIOD        = 200,
  parameter int CNT_W         = 16
) (
  input  logic                 fastclk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 auto_en,
  input  logic [2**ADDR_W-1:0] dump_mask,
  output logic [ADDR_W-1:0]    switch_select,
  input  logic [DATA_W-1:0]    reg_read_data_1,
  output logic                 switch_run,
  output logic                 dump_valid,
  input  logic                 dump_ready,
  output logic [ADDR_W-1:0]    dump_index,
  output logic [DATA_W-1:0]    dump_data,
  output logic                 dump_last,
  output logic                 busy,
  output logic [CNT_W-1:0]     frame_count
);

  localparam int MASK_W = 2**ADDR_W;
  localparam int IDLE_W = $clog2(PERIOD + 1);
  localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int GAP_W  = $clog2(GAP_CYCLES + 2);
  localparam int RUN_W  = $clog2(RUN_CYCLES + 1);
  localparam int SG_W   = (SET_W > GAP_W) ? SET_W : GAP_W;
  localparam int STEP_W = (SG_W > RUN_W) ? SG_W : RUN_W;

  localparam logic [IDLE_W-1:0] IDLE_LAST   = IDLE_W'(PERIOD - 1);
  localparam logic [STEP_W-1:0] SETTLE_LAST = STEP_W'(SETTLE_CYCLES - 1);
  localparam logic [STEP_W-1:0] GAP_LAST    = STEP_W'(GAP_CYCLES);
  localparam logic [STEP_W-1:0] RUN_LAST    = STEP_W'(RUN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_PRESENT,
    S_GAP,
    S_RUN
  } state_t;

  state_t              state, state_d;
  logic [IDLE_W-1:0]   idle_cnt, idle_cnt_d;
  logic [STEP_W-1:0]   step_cnt, step_cnt_d;
  logic [MASK_W-1:0]   mask_q, mask_d;
  logic [ADDR_W-1:0]   select_d, index_d;
  logic [DATA_W-1:0]   data_d;
  logic                last_d, valid_d, run_d, busy_d;
  logic [CNT_W-1:0]    count_d;
  logic [MASK_W-1:0]   mask_above;

  // Lowest set bit of m at or above position 'from'; only called with a bit known to exist.
  function automatic logic [ADDR_W-1:0] first_set_from(input logic [MASK_W-1:0] m,
                                                       input logic [ADDR_W:0]   from);
    logic [ADDR_W-1:0] idx;
    idx = '0;
    for (int i = MASK_W - 1; i >= 0; i--) begin
      if (m[i] && (i >= int'(from))) idx = ADDR_W'(i);
    end
    return idx;
  endfunction

  assign mask_above = (mask_q >> switch_select) >> 1;

  always_comb begin
    state_d    = state;
    idle_cnt_d = idle_cnt;
    step_cnt_d = step_cnt;
    mask_d     = mask_q;
    select_d   = switch_select;
    index_d    = dump_index;
    data_d     = dump_data;
    last_d     = dump_last;
    valid_d    = dump_valid;
    run_d      = switch_run;
    count_d    = frame_count;

    case (state)
      S_IDLE: begin
        idle_cnt_d = idle_cnt + IDLE_W'(1);
        if (start || (auto_en && (idle_cnt == IDLE_LAST))) begin
          idle_cnt_d = '0;
          step_cnt_d = '0;
          mask_d     = dump_mask;
          if (dump_mask != '0) begin
            select_d = first_set_from(dump_mask, '0);
            state_d  = S_SELECT;
          end else begin
            state_d  = S_GAP;
          end
        end
      end
      S_SELECT: begin
        if (step_cnt == SETTLE_LAST) begin
          step_cnt_d = '0;
          data_d     = reg_read_data_1;
          index_d    = switch_select;
          last_d     = (mask_above == '0);
          valid_d    = 1'b1;
          state_d    = S_PRESENT;
        end else begin
          step_cnt_d = step_cnt + STEP_W'(1);
        end
      end
      S_PRESENT: begin
        if (dump_valid && dump_ready) begin
          valid_d = 1'b0;
          if (dump_last) begin
            state_d  = S_GAP;
          end else begin
            select_d = first_set_from(mask_q, {1'b0, switch_select} + (ADDR_W + 1)'(1));
            state_d  = S_SELECT;
          end
        end
      end
      S_GAP: begin
        // GAP holds GAP_CYCLES+1 cycles so switch_run rises GAP_CYCLES after the cycle following the last beat.
        if (step_cnt == GAP_LAST) begin
          step_cnt_d = '0;
          run_d      = 1'b1;
          state_d    = S_RUN;
        end else begin
          step_cnt_d = step_cnt + STEP_W'(1);
        end
      end
      S_RUN: begin
        if (step_cnt == RUN_LAST) begin
          step_cnt_d = '0;
          run_d      = 1'b0;
          count_d    = frame_count + CNT_W'(1);
          state_d    = S_IDLE;
        end else begin
          step_cnt_d = step_cnt + STEP_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge fastclk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      idle_cnt      <= '0;
      step_cnt      <= '0;
      mask_q        <= '0;
      switch_select <= '0;
      dump_index    <= '0;
      dump_data     <= '0;
      dump_last     <= 1'b0;
      dump_valid    <= 1'b0;
      switch_run    <= 1'b0;
      frame_count   <= '0;
      busy          <= 1'b0;
    end else begin
      state         <= state_d;
      idle_cnt      <= idle_cnt_d;
      step_cnt      <= step_cnt_d;
      mask_q        <= mask_d;
      switch_select <= select_d;
      dump_index    <= index_d;
      dump_data     <= data_d;
      dump_last     <= last_d;
      dump_valid    <= valid_d;
      switch_run    <= run_d;
      frame_count   <= count_d;
      busy          <= busy_d;
    end
  end

endmodule

// File: tb/tb_reg_dump_sequencer.sv
// tb/tb_reg_dump_sequencer.sv - scoreboard bench for reg_dump_sequencer
// Expected beats come from the latched mask and a model register file; a negedge monitor checks them.
module tb_reg_dump_sequencer;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int MASK_W = 32;
  localparam int SETTLE = 4;
  localparam int GAP    = 2;
  localparam int RUN    = 16;
  localparam int PERIOD = 50;
  localparam int CNT_W  = 2;

  logic              fastclk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              auto_en = 1'b0;
  logic [MASK_W-1:0] dump_mask = '0;
  logic [ADDR_W-1:0] switch_select;
  logic [DATA_W-1:0] reg_read_data_1;
  logic              switch_run;
  logic              dump_valid;
  logic              dump_ready = 1'b1;
  logic [ADDR_W-1:0] dump_index;
  logic [DATA_W-1:0] dump_data;
  logic              dump_last;
  logic              busy;
  logic [CNT_W-1:0]  frame_count;

  logic [DATA_W-1:0] core_regs [MASK_W];
  assign reg_read_data_1 = core_regs[switch_select];

  reg_dump_sequencer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SETTLE_CYCLES(SETTLE), .GAP_CYCLES(GAP),
    .RUN_CYCLES(RUN), .PERIOD(PERIOD), .CNT_W(CNT_W)
  ) dut (
    .fastclk(fastclk), .reset(reset), .start(start), .auto_en(auto_en),
    .dump_mask(dump_mask), .switch_select(switch_select), .reg_read_data_1(reg_read_data_1),
    .switch_run(switch_run), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_index(dump_index), .dump_data(dump_data), .dump_last(dump_last),
    .busy(busy), .frame_count(frame_count)
  );

  always #5 fastclk = ~fastclk;

  typedef struct {
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       mon_e;
  int          checks = 0;
  int          failures = 0;
  int          edge_n = 0;
  logic [31:0] model_mask = '0;
  int          ready_mode = 0;
  int          bp_left = 0;
  int          hs_in_frame = 0;
  int          prev_hs_edge = 0;
  int          exp_rise_edge = -1;
  int          exp_fc = 0;
  int          run_len = 0;
  int          idle_len = 0;
  bit          prev_busy = 0;
  bit          prev_run = 0;
  bit          auto_measure = 0;
  bit          stall_pending = 0;
  logic [ADDR_W-1:0] st_idx, st_sel;
  logic [DATA_W-1:0] st_data;

  always @(posedge fastclk) edge_n++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic int lowest(input logic [31:0] m);
    int r = -1;
    for (int i = MASK_W - 1; i >= 0; i--) if (m[i]) r = i;
    return r;
  endfunction

  function automatic int highest(input logic [31:0] m);
    int r = -1;
    for (int i = 0; i < MASK_W; i++) if (m[i]) r = i;
    return r;
  endfunction

  // Sink ready: always, random, or a single 7-cycle stall on the third beat of the frame.
  always begin
    @(posedge fastclk);
    #1;
    case (ready_mode)
      0: dump_ready = 1'b1;
      1: dump_ready = ($urandom_range(0, 3) != 0);
      default: begin
        if (dump_valid && hs_in_frame == 2 && bp_left > 0) begin
          dump_ready = 1'b0;
          bp_left--;
        end else begin
          dump_ready = 1'b1;
        end
      end
    endcase
  end

  always @(negedge fastclk) begin
    if (!reset) begin
      exp_q.delete();
      exp_fc = 0;
      prev_busy = 0;
      prev_run = 0;
      run_len = 0;
      idle_len = 0;
      stall_pending = 0;
      hs_in_frame = 0;
      exp_rise_edge = -1;
    end else begin
      if (stall_pending) begin
        check("stall_valid", dump_valid, 1);
        check("stall_index", dump_index, st_idx);
        check("stall_data", dump_data, st_data);
        check("stall_select", switch_select, st_sel);
        stall_pending = 0;
      end
      if (dump_valid && !dump_ready) begin
        stall_pending = 1;
        st_idx  = dump_index;
        st_data = dump_data;
        st_sel  = switch_select;
      end

      if (busy && !prev_busy) begin
        if (auto_measure) check("auto_idle_gap", idle_len, PERIOD);
        hs_in_frame = 0;
        for (int i = 0; i < MASK_W; i++) begin
          if (model_mask[i]) begin
            mon_e.idx  = ADDR_W'(i);
            mon_e.data = core_regs[i];
            mon_e.last = (i == highest(model_mask));
            exp_q.push_back(mon_e);
          end
        end
        if (model_mask == 0) exp_rise_edge = edge_n + 1 + GAP;
      end
      if (!busy) idle_len++;
      else idle_len = 0;
      prev_busy = busy;

      if (dump_valid && dump_ready) begin
        check("beat_available", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("beat_index", dump_index, mon_e.idx);
          check("beat_data", dump_data, mon_e.data);
          check("beat_last", dump_last, mon_e.last);
          if (mon_e.last) exp_rise_edge = edge_n + 2 + GAP;
        end
        if (ready_mode == 0 && hs_in_frame > 0) check("beat_spacing", edge_n - prev_hs_edge, SETTLE + 1);
        prev_hs_edge = edge_n;
        hs_in_frame++;
      end

      if (switch_run && !prev_run) begin
        check("run_rise_edge", edge_n, exp_rise_edge);
        check("run_no_pending_beats", exp_q.size(), 0);
        run_len = 1;
        exp_rise_edge = -1;
      end else if (switch_run) begin
        run_len++;
      end else if (prev_run) begin
        check("run_length", run_len, RUN);
        exp_fc = (exp_fc + 1) % (1 << CNT_W);
        check("frame_count", frame_count, exp_fc);
      end
      prev_run = switch_run;
    end
  end

  task automatic do_start(input logic [31:0] mask);
    foreach (core_regs[i]) core_regs[i] = $urandom;
    model_mask = mask;
    @(posedge fastclk);
    #1;
    dump_mask = mask;
    start = 1'b1;
    @(posedge fastclk);
    #1;
    start = 1'b0;
    @(negedge fastclk);
    check("start_busy", busy, 1);
    if (mask != 0) begin
      check("start_select", switch_select, lowest(mask));
      repeat (SETTLE - 1) @(negedge fastclk);
      check("first_valid_early", dump_valid, 0);
      @(negedge fastclk);
      check("first_valid_on_time", dump_valid, 1);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge fastclk);
      n++;
    end
    check("frame_timeout", (n < 3000), 1);
    @(negedge fastclk);
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!busy && n < 300) begin
      @(negedge fastclk);
      n++;
    end
    check("busy_timeout", (n < 300), 1);
  endtask

  initial begin
    logic [31:0] m;
    int busy_seen;
    foreach (core_regs[i]) core_regs[i] = $urandom;
    #3 reset = 1'b0;
    repeat (3) @(negedge fastclk);
    check("rst_switch_run", switch_run, 0);
    check("rst_dump_valid", dump_valid, 0);
    check("rst_dump_last", dump_last, 0);
    check("rst_switch_select", switch_select, 0);
    check("rst_dump_index", dump_index, 0);
    check("rst_dump_data", dump_data, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_busy", busy, 0);
    @(posedge fastclk);
    #1 reset = 1'b1;
    repeat (3) @(negedge fastclk);

    ready_mode = 0;
    do_start(32'h03FF_FF00);
    wait_idle();

    ready_mode = 2;
    bp_left = 7;
    do_start(32'h03FF_FF00);
    wait_idle();
    check("backpressure_applied", bp_left, 0);

    ready_mode = 0;
    do_start(32'h0);
    wait_idle();

    repeat (4) begin
      do_start(32'h8000_0001);
      wait_idle();
    end

    ready_mode = 1;
    for (int f = 0; f < 6; f++) begin
      m = $urandom;
      if (f == 2) m = 32'h0;
      else if (f % 2 == 1) m = m & $urandom & $urandom;
      do_start(m);
      dump_mask = $urandom;
      @(posedge fastclk);
      #1 start = 1'b1;
      @(posedge fastclk);
      #1 start = 1'b0;
      wait_idle();
      repeat ($urandom_range(0, 5)) @(negedge fastclk);
    end

    ready_mode = 0;
    model_mask = 32'h0000_FF00;
    dump_mask = 32'h0000_FF00;
    auto_en = 1'b1;
    wait_busy();
    #1 auto_measure = 1;
    repeat (3) begin
      wait_idle();
      wait_busy();
      @(posedge fastclk);
      #1 start = 1'b1;
      @(posedge fastclk);
      #1 start = 1'b0;
    end
    auto_en = 1'b0;
    #1 auto_measure = 0;
    wait_idle();

    ready_mode = 0;
    do_start(32'h0000_0F0F);
    begin
      int n = 0;
      while (!switch_run && n < 500) begin
        @(negedge fastclk);
        n++;
      end
      check("run_wait_timeout", (n < 500), 1);
    end
    repeat (3) @(negedge fastclk);
    #2 reset = 1'b0;
    #1;
    check("async_rst_switch_run", switch_run, 0);
    check("async_rst_dump_valid", dump_valid, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_frame_count", frame_count, 0);
    repeat (2) @(negedge fastclk);
    @(posedge fastclk);
    #1 reset = 1'b1;
    busy_seen = 0;
    repeat (60) begin
      @(negedge fastclk);
      if (busy || switch_run || dump_valid) busy_seen++;
    end
    check("idle_after_reset", busy_seen, 0);
    do_start(32'h0000_0005);
    wait_idle();
    check("frame_count_after_reset", frame_count, 1);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at edge %0d", edge_n);
    $fatal(1, "watchdog");
  end

endmodule
